seq_divider: RTL and testbench

//  Iterative 64-bit integer divider for the pipeline's execute stage (UDIV/SDIV).

---
 rtl/div_pkg.sv | 5 +
 rtl/seq_divider_sub_stage.sv | 11 +
 rtl/seq_divider.sv | 112 +++++++++++
 tb/tb_seq_divider.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
   localparam int DIV_DATA_W = 64;
endpackage

// File: rtl/seq_divider_sub_stage.sv
// Combinational (DATA_W+1)-bit subtractor: diff = a - b, borrow when a < b.
module sub_stage #(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W:0] a,
   input  logic [DATA_W:0] b,
   output logic [DATA_W:0] diff,
   output logic            borrow
);
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one shift-subtract step per cycle, signed/unsigned.
// Two subtractors are time-shared: operand negation, the RUN step and result negation.
module seq_divider
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              signed_op,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero
);
   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam int MSB   = DATA_W - 1;

   div_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [DATA_W:0]  r, d;
   logic [MSB:0]     q;
   logic             neg_q, neg_r;
   logic [DATA_W:0]  r_sh, a_a, a_b, a_diff, b_b, b_diff;
   logic             a_borrow, b_borrow, div_zero;

   assign r_sh = {r[MSB:0], q[MSB]};
   // In IDLE the B subtractor computes 0 - sext(divisor): it borrows iff divisor != 0
   assign div_zero = ~b_borrow;

   sub_stage #(.DATA_W(DATA_W)) u_sub_a (
      .a(a_a), .b(a_b), .diff(a_diff), .borrow(a_borrow)
   );
   sub_stage #(.DATA_W(DATA_W)) u_sub_b (
      .a('0), .b(b_b), .diff(b_diff), .borrow(b_borrow)
   );

   always_comb begin
      state_nx = state;
      a_a      = '0;
      a_b      = {dividend[MSB], dividend};
      b_b      = {divisor[MSB], divisor};
      case (state)
         IDLE: if (start) state_nx = div_zero ? DONE : RUN;
         RUN: begin
            a_a = r_sh;
            a_b = d;
            if (cnt == CNT_W'(1)) state_nx = FIX;
         end
         FIX: begin
            a_b      = r;
            b_b      = {1'b0, q};
            state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         d           <= '0;
         q           <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         done  <= (state_nx == DONE);
         case (state)
            IDLE: if (start) begin
               if (div_zero) begin
                  quotient    <= '0;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
                  // sign-extended negation keeps |MIN| = 2^(DATA_W-1) exact
                  q     <= (signed_op && dividend[MSB]) ? a_diff[MSB:0] : dividend;
                  d     <= (signed_op && divisor[MSB]) ? b_diff : {1'b0, divisor};
                  neg_q <= signed_op & (dividend[MSB] ^ divisor[MSB]);
                  neg_r <= signed_op & dividend[MSB];
                  r     <= '0;
                  cnt   <= CNT_W'(DATA_W);
               end
            end
            RUN: begin
               r   <= a_borrow ? r_sh : a_diff;
               q   <= {q[MSB-1:0], ~a_borrow};
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               quotient    <= neg_q ? b_diff[MSB:0] : q;
               remainder   <= neg_r ? a_diff[MSB:0] : r[MSB:0];
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at accept, checked on done.
module tb_seq_divider;
   localparam int W = 64;
   localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
   localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   seq_divider dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           due;
   } exp_t;

   exp_t         sb[$];
   exp_t         e_pop;
   int           checks = 0, errors = 0, cyc = 0;
   logic [W-1:0] last_q = '0, last_r = '0;
   logic         last_z = 1'b0, prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: busy vs outstanding work, done width, scoreboard, hold in IDLE
   always @(negedge clk) begin
      if (!rst_n) prev_done = 1'b0;
      else begin
         checks++;
         if (busy !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, sb.size() != 0);
         end
         if (done) begin
            checks++;
            if (prev_done) begin
               errors++;
               $display("FAIL done_width cyc=%0d done high two cycles", cyc);
            end
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done cyc=%0d q=%h r=%h", cyc, quotient, remainder);
            end else begin
               e_pop = sb.pop_front();
               checks += 4;
               if (cyc !== e_pop.due) begin
                  errors++; $display("FAIL latency got cyc %0d exp %0d", cyc, e_pop.due);
               end
               if (quotient !== e_pop.q) begin
                  errors++; $display("FAIL quotient got %h exp %h", quotient, e_pop.q);
               end
               if (remainder !== e_pop.r) begin
                  errors++; $display("FAIL remainder got %h exp %h", remainder, e_pop.r);
               end
               if (div_by_zero !== e_pop.z) begin
                  errors++; $display("FAIL div_by_zero got %b exp %b", div_by_zero, e_pop.z);
               end
               last_q = e_pop.q; last_r = e_pop.r; last_z = e_pop.z;
            end
         end else if (!busy) begin
            checks++;
            if ({quotient, remainder, div_by_zero} !== {last_q, last_r, last_z}) begin
               errors++;
               $display("FAIL hold cyc=%0d got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                        cyc, quotient, remainder, div_by_zero, last_q, last_r, last_z);
            end
         end
         if (sb.size() != 0 && cyc > sb[0].due) begin
            checks++; errors++;
            $display("FAIL done_timeout cyc=%0d exp by %0d", cyc, sb[0].due);
            void'(sb.pop_front());
         end
         prev_done = done;
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int lat);
      exp_t e;
      @(negedge clk);
      dividend = a; divisor = b; signed_op = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e.q = eq; e.r = er; e.z = ez; e.due = cyc + lat - 1;
      sb.push_back(e);
      dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom}; signed_op = ~s;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL wait_idle still %0d pending", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL reset got busy=%b done=%b z=%b q=%h r=%h exp all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_udiv();
      issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 66);
      wait_idle();
      issue(ONES, 64'd3, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 1'b0, 66);
      wait_idle();
   endtask

   task automatic test_sdiv();
      issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
      wait_idle();
      issue(MIN, ONES, 1'b1, MIN, 64'd0, 1'b0, 66);
      wait_idle();
      issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 66);
      wait_idle();
   endtask

   // start held through the DONE cycle must not launch a second operation
   task automatic test_zero();
      exp_t e;
      @(negedge clk);
      dividend = 64'h1234; divisor = '0; signed_op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      e.q = '0; e.r = 64'h1234; e.z = 1'b1; e.due = cyc;
      sb.push_back(e);
      dividend = 64'd9; divisor = 64'd2;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ignored();
      issue(ONES, 64'd3, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 1'b0, 66);
      repeat (9) @(negedge clk);
      dividend = 64'd9; divisor = 64'd2; signed_op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      checks++;
      if (quotient !== 64'h5555_5555_5555_5555 || remainder !== 64'd0) begin
         errors++;
         $display("FAIL ignored_start got q=%h r=%h exp q=5555555555555555 r=0",
                  quotient, remainder);
      end
   endtask

   task automatic test_reset_abort();
      issue(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 66);
      repeat (28) @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL reset_abort got busy=%b done=%b z=%b q=%h r=%h exp all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      last_q = '0; last_r = '0; last_z = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (70) @(negedge clk);
      issue(64'd9, 64'd2, 1'b0, 64'd4, 64'd1, 1'b0, 66);
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]        a, b, eq, er;
      logic signed [W-1:0] sa, sbv;
      logic                s;
      for (int i = 0; i < 8; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 60);
         if (b == '0) b = 64'd1;
         s = i[0];
         if (s && a == MIN && b == ONES) b = 64'd5;
         if (s) begin
            sa = a; sbv = b;
            eq = sa / sbv; er = sa % sbv;
         end else begin
            eq = a / b; er = a % b;
         end
         issue(a, b, s, eq, er, 1'b0, 66);
         wait_idle();
      end
   endtask

   initial begin
      test_reset();
      test_udiv();
      test_sdiv();
      test_zero();
      test_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
